// File: rtl/fixedpoint_requantizer_if.sv
// Handshake bundle for the requantizer: input beat, output beat, status.
// master drives operands and out_ready; slave returns results.
interface fixedpoint_requantizer_if #(
  parameter int N    = 4,
  parameter int BA   = 27,
  parameter int BB   = 16,
  parameter int BC   = 27,
  parameter int BS   = 5,
  parameter int BO   = 8,
  parameter int BCNT = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [N*BA-1:0] a;
  logic [N*BA-1:0] d;
  logic [N*BB-1:0] b;
  logic [N*BC-1:0] c;
  logic [BS-1:0]   shr;
  logic            out_valid;
  logic            out_ready;
  logic [N*BO-1:0] p;
  logic [N-1:0]    out_sat;
  logic [BCNT-1:0] sat_cnt;

  modport master (
    output in_valid, a, d, b, c, shr, out_ready,
    input  in_ready, out_valid, p, out_sat, sat_cnt
  );

  modport slave (
    input  in_valid, a, d, b, c, shr, out_ready,
    output in_ready, out_valid, p, out_sat, sat_cnt
  );
endinterface

// File: rtl/fixedpoint_requantizer.sv
// Five-stage per-lane (a+d)*b+c, rounding right shift, saturate to BO bits.
// Ports: clk, clr (sync active-high), bus (slave side of the handshake).
module fixedpoint_requantizer #(
  parameter int N    = 4,
  parameter int BA   = 27,
  parameter int BB   = 16,
  parameter int BC   = 27,
  parameter int BS   = 5,
  parameter int BO   = 8,
  parameter int BCNT = 16
) (
  input logic                     clk,
  input logic                     clr,
  fixedpoint_requantizer_if.slave bus
);
  localparam int BM = BA + BB + 2;
  localparam int BP = ((BM > BC) ? BM : BC) + 1;

  localparam logic signed [BP-1:0] QMAX =
    {{(BP-BO+1){1'b0}}, {(BO-1){1'b1}}};
  localparam logic signed [BP-1:0] QMIN =
    {{(BP-BO+1){1'b1}}, {(BO-1){1'b0}}};

  logic [4:0]      r_v;
  logic [N*BO-1:0] r_p;
  logic [N-1:0]    r_sat;
  logic [BCNT-1:0] r_cnt;

  logic [BA-1:0]   r1_a [N];
  logic [BA-1:0]   r1_d [N];
  logic [BB-1:0]   r1_b [N];
  logic [BC-1:0]   r1_c [N];
  logic [BS-1:0]   r1_shr;

  logic [BA:0]     r2_s [N];
  logic [BB-1:0]   r2_b [N];
  logic [BC-1:0]   r2_c [N];
  logic [BS-1:0]   r2_shr;

  logic [BM-1:0]   r3_m [N];
  logic [BC-1:0]   r3_c [N];
  logic [BS-1:0]   r3_shr;

  logic [BP-1:0]   r4_t [N];
  logic [BS-1:0]   r4_shr;

  logic                 w_adv;
  logic [BA:0]          w_s [N];
  logic [BM-1:0]        w_m [N];
  logic [BP-1:0]        w_rnd;
  logic [BP-1:0]        w_t [N];
  logic signed [BP-1:0] w_q [N];
  logic [N*BO-1:0]      w_p;
  logic [N-1:0]         w_sat;

  assign w_adv         = !r_v[4] || bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_v[4];
  assign bus.p         = r_p;
  assign bus.out_sat   = r_sat;
  assign bus.sat_cnt   = r_cnt;

  // Half-LSB of the shifted result, so ties round toward +inf.
  always_comb begin
    w_rnd = '0;
    if (r3_shr != '0)
      w_rnd = {{(BP-1){1'b0}}, 1'b1} << (r3_shr - 1'b1);
  end

  // Operands are sign-extended to the result width first, so plain
  // modular add/multiply yields the exact two's-complement value.
  always_comb begin
    w_p   = '0;
    w_sat = '0;
    for (int i = 0; i < N; i++) begin
      w_s[i] = {r1_a[i][BA-1], r1_a[i]}
             + {r1_d[i][BA-1], r1_d[i]};
      w_m[i] = {{(BM-BA-1){r2_s[i][BA]}}, r2_s[i]}
             * {{(BM-BB){1'b0}}, r2_b[i]};
      w_t[i] = {{(BP-BM){r3_m[i][BM-1]}}, r3_m[i]}
             + {{(BP-BC){r3_c[i][BC-1]}}, r3_c[i]}
             + w_rnd;
      w_q[i] = $signed(r4_t[i]) >>> r4_shr;
      w_p[i*BO +: BO] = w_q[i][BO-1:0];
      if (w_q[i] > QMAX) begin
        w_p[i*BO +: BO] = QMAX[BO-1:0];
        w_sat[i]        = 1'b1;
      end else if (w_q[i] < QMIN) begin
        w_p[i*BO +: BO] = QMIN[BO-1:0];
        w_sat[i]        = 1'b1;
      end
    end
  end

  // Datapath registers; contents behind a clear valid bit are don't-care.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r1_shr <= bus.shr;
      r2_shr <= r1_shr;
      r3_shr <= r2_shr;
      r4_shr <= r3_shr;
      for (int i = 0; i < N; i++) begin
        r1_a[i] <= bus.a[i*BA +: BA];
        r1_d[i] <= bus.d[i*BA +: BA];
        r1_b[i] <= bus.b[i*BB +: BB];
        r1_c[i] <= bus.c[i*BC +: BC];
        r2_s[i] <= w_s[i];
        r2_b[i] <= r1_b[i];
        r2_c[i] <= r1_c[i];
        r3_m[i] <= w_m[i];
        r3_c[i] <= r2_c[i];
        r4_t[i] <= w_t[i];
      end
    end
  end

  // Valid chain, output word and event counter.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_v   <= '0;
      r_p   <= '0;
      r_sat <= '0;
      r_cnt <= '0;
    end else begin
      if (r_v[4] && bus.out_ready && (|r_sat) && (r_cnt != '1))
        r_cnt <= r_cnt + BCNT'(1);
      if (w_adv) begin
        r_v   <= {r_v[3:0], bus.in_valid};
        r_p   <= r_v[3] ? w_p : '0;
        r_sat <= r_v[3] ? w_sat : '0;
      end
    end
  end
endmodule

// File: tb/tb_fixedpoint_requantizer.sv
// Bench for fixedpoint_requantizer: directed vectors plus a cycle model.
// Two DUTs share stimulus; the second has a 2-bit saturation counter.
module tb_fixedpoint_requantizer;
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  fixedpoint_requantizer_if #(.N(2), .BA(8), .BB(8), .BC(16),
    .BS(4), .BO(8), .BCNT(16)) bus ();
  fixedpoint_requantizer_if #(.N(2), .BA(8), .BB(8), .BC(16),
    .BS(4), .BO(8), .BCNT(2)) bus2 ();

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.a         = bus.a;
  assign bus2.d         = bus.d;
  assign bus2.b         = bus.b;
  assign bus2.c         = bus.c;
  assign bus2.shr       = bus.shr;
  assign bus2.out_ready = bus.out_ready;

  fixedpoint_requantizer #(.N(2), .BA(8), .BB(8), .BC(16),
    .BS(4), .BO(8), .BCNT(16)) dut (
    .clk(clk), .clr(clr), .bus(bus));
  fixedpoint_requantizer #(.N(2), .BA(8), .BB(8), .BC(16),
    .BS(4), .BO(8), .BCNT(2)) dut2 (
    .clk(clk), .clr(clr), .bus(bus2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, floor shift, clip to 8 bits.
  function automatic void lane(input longint a, input longint d,
      input longint b, input longint c, input int sh,
      output longint pv, output bit s);
    longint t;
    longint q;
    t = (a + d) * b + c + ((sh == 0) ? 0 : (longint'(1) << (sh - 1)));
    q = t >>> sh;
    s = 1'b1;
    if (q > 127)       pv = 127;
    else if (q < -128) pv = -128;
    else begin
      pv = q;
      s  = 1'b0;
    end
  endfunction

  typedef struct {
    longint p0;
    longint p1;
    bit [1:0] s;
    int age;
  } exp_t;

  exp_t   mq[$];
  exp_t   e;
  bit     chk_en = 1'b0;
  bit     ev;
  bit     adv;
  int     cnt1 = 0;
  int     cnt2 = 0;
  int     n_xfer = 0;

  // Beats age one step per advancing edge; the head is presented once
  // it has seen five such edges.
  always @(negedge clk) begin
    if (chk_en) begin
      ev = (mq.size() > 0) && (mq[0].age >= 5);
      chk("out_valid", bus.out_valid, ev);
      chk("in_ready", bus.in_ready, !ev || bus.out_ready);
      if (ev) begin
        chk("p0", $signed(bus.p[7:0]), mq[0].p0);
        chk("p1", $signed(bus.p[15:8]), mq[0].p1);
        chk("out_sat", bus.out_sat, mq[0].s);
      end else begin
        chk("p_idle", bus.p, 0);
        chk("sat_idle", bus.out_sat, 0);
      end
      chk("sat_cnt", bus.sat_cnt, cnt1);
      chk("sat_cnt2", bus2.sat_cnt, cnt2);
      if (bus.out_valid && bus.out_ready) n_xfer++;
      if (clr) begin
        mq.delete();
        cnt1 = 0;
        cnt2 = 0;
      end else begin
        adv = !ev || bus.out_ready;
        if (ev && bus.out_ready) begin
          if (mq[0].s != 0) begin
            if (cnt1 < 65535) cnt1++;
            if (cnt2 < 3) cnt2++;
          end
          void'(mq.pop_front());
        end
        if (adv && bus.in_valid) begin
          lane($signed(bus.a[7:0]), $signed(bus.d[7:0]),
               longint'(bus.b[7:0]), $signed(bus.c[15:0]),
               int'(bus.shr), e.p0, e.s[0]);
          lane($signed(bus.a[15:8]), $signed(bus.d[15:8]),
               longint'(bus.b[15:8]), $signed(bus.c[31:16]),
               int'(bus.shr), e.p1, e.s[1]);
          e.age = 0;
          mq.push_back(e);
        end
        if (adv)
          for (int j = 0; j < mq.size(); j++) mq[j].age++;
      end
    end
  end

  task automatic set_beat(input logic [7:0] a0, input logic [7:0] d0,
      input logic [7:0] b0, input logic [15:0] c0,
      input logic [7:0] a1, input logic [7:0] d1,
      input logic [7:0] b1, input logic [15:0] c1,
      input logic [3:0] sh);
    bus.a   = {a1, a0};
    bus.d   = {d1, d0};
    bus.b   = {b1, b0};
    bus.c   = {c1, c0};
    bus.shr = sh;
  endtask

  task automatic handshake();
    int k;
    bus.in_valid = 1'b1;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    if (k == 50) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] a0, input logic [7:0] d0,
      input logic [7:0] b0, input logic [15:0] c0,
      input logic [7:0] a1, input logic [7:0] d1,
      input logic [7:0] b1, input logic [15:0] c1,
      input logic [3:0] sh);
    set_beat(a0, d0, b0, c0, a1, d1, b1, c1, sh);
    handshake();
  endtask

  task automatic send_rand(input logic [3:0] sh);
    set_beat(8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom), sh);
    handshake();
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.out_valid && cyc < 20);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int lat;
  int x0;
  logic [15:0] held;
  int vals[5];
  int got;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_beat(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_p", bus.p, 0);
    chk("rst_sat_cnt", bus.sat_cnt, 0);
    @(posedge clk);
    #1;

    send(10, -3, 20, 5, -3, 0, 2, 0, 2);
    wait_out(lat);
    chk("round_latency", lat, 5);
    chk("round_p0", $signed(bus.p[7:0]), 36);
    chk("round_p1", $signed(bus.p[15:8]), -1);
    chk("round_sat", bus.out_sat, 0);
    @(posedge clk);
    #1;

    send(127, 127, 255, 0, -128, -128, 255, 0, 0);
    wait_out(lat);
    chk("sat_p0", $signed(bus.p[7:0]), 127);
    chk("sat_p1", $signed(bus.p[15:8]), -128);
    chk("sat_flags", bus.out_sat, 3);
    chk("sat_cnt_before", bus.sat_cnt, 0);
    @(negedge clk);
    chk("sat_cnt_after", bus.sat_cnt, 1);
    @(posedge clk);
    #1;

    fork
      begin
        for (int i = 0; i < 20; i++) begin
          set_beat(8'($urandom), 8'($urandom), 8'($urandom),
                   16'($urandom), 8'($urandom), 8'($urandom),
                   8'($urandom), 16'($urandom), 3);
          bus.in_valid = 1'b1;
          @(posedge clk);
          #1;
        end
        bus.in_valid = 1'b0;
      end
      begin
        int first = -1;
        int last  = -1;
        int n     = 0;
        for (int j = 0; j < 40; j++) begin
          @(negedge clk);
          if (bus.out_valid) begin
            n++;
            if (first < 0) first = j;
            last = j;
          end
        end
        chk("stream_count", n, 20);
        chk("stream_span", last - first, 19);
      end
    join
    @(posedge clk);
    #1;

    x0 = n_xfer;
    fork
      for (int i = 0; i < 10; i++) send_rand(1);
      begin
        repeat (8) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        held = bus.p;
        chk("bp_in_ready0", bus.in_ready, 0);
        chk("bp_valid", bus.out_valid, 1);
        repeat (2) begin
          @(negedge clk);
          chk("bp_in_ready", bus.in_ready, 0);
          chk("bp_p_held", bus.p, held);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    repeat (12) @(posedge clk);
    #1;
    chk("bp_transfers", n_xfer - x0, 10);

    bus.out_ready = 1'b0;
    send(127, 127, 255, 0, 1, 1, 1, 1, 0);
    send(1, 2, 3, 4, 5, 6, 7, 8, 1);
    send(-5, 2, 9, 100, 3, 3, 3, 3, 2);
    repeat (4) @(posedge clk);
    #1 clr = 1'b1;
    @(negedge clk);
    chk("stall_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    clr = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("clr_out_valid", bus.out_valid, 0);
    chk("clr_p", bus.p, 0);
    chk("clr_sat_cnt", bus.sat_cnt, 0);
    @(posedge clk);
    #1;
    send(4, 4, 4, 0, -4, 0, 4, 0, 1);
    wait_out(lat);
    chk("clr_latency", lat, 5);
    chk("clr_p0", $signed(bus.p[7:0]), 16);
    chk("clr_p1", $signed(bus.p[15:8]), -8);
    @(posedge clk);
    #1;

    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    got = 0;
    fork
      for (int i = 0; i < 5; i++)
        send(100, 100, 200, 0, -100, -100, 200, 0, 1);
      begin
        bit prev = 1'b0;
        for (int j = 0; j < 30 && got < 5; j++) begin
          @(negedge clk);
          if (prev) begin
            vals[got] = int'(bus2.sat_cnt);
            got++;
          end
          prev = bus.out_valid && bus.out_ready;
        end
      end
    join
    chk("ceil_count", got, 5);
    chk("ceil_0", vals[0], 1);
    chk("ceil_1", vals[1], 2);
    chk("ceil_2", vals[2], 3);
    chk("ceil_3", vals[3], 3);
    chk("ceil_4", vals[4], 3);
    chk("ceil_wide", bus.sat_cnt, 5);

    repeat (10) @(posedge clk);
    #1;
    chk("drained", mq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
